// File: rtl/if_id_skid_reg.sv
// ---------------------------------------------------------------------------
// if_id_skid_reg
//
// IF/ID pipeline register with a one-entry skid buffer. It sits between the
// instruction-memory/PC stage and decode. The register captures the fetched
// instruction and its PC+4, and presents them to decode with a valid flag.
// The skid entry holds one extra instruction, so a fetch that arrives in the
// same cycle decode stalls is never lost.
//
// Optional feature macro: IFID_PERF_CNT_EN
//   When defined, the block keeps saturating counters of stall and flush
//   cycles. When undefined, no counter registers exist and both counter
//   ports are tied to zero.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-low reset
//   valid_i      fetch presents a valid instruction
//   ready_o      block can accept; fire = valid_i & ready_o
//   pc_plus4_i   PC+4 of the fetched instruction
//   instr_i      fetched instruction
//   stall_i      decode is not consuming this cycle
//   flush_i      discard every held and incoming instruction
//   valid_o      output slot holds a real instruction
//   pc_plus4_o   registered PC+4
//   instr_o      registered instruction; NOP_INSTR while valid_o = 0
//   opcode_o, rs_o, rt_o, rd_o, shamt_o, funct_o, imm16_o
//                MIPS field slices of instr_o
//   stall_cnt_o  count of stalled cycles with a valid output (optional)
//   flush_cnt_o  count of flush cycles (optional)
// ---------------------------------------------------------------------------
module if_id_skid_reg #(
    parameter int unsigned         PC_W      = 32,
    // The MIPS field slicing below assumes INSTR_W = 32.
    parameter int unsigned         INSTR_W   = 32,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [PC_W-1:0]    pc_plus4_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               stall_i,
    input  logic               flush_i,
    output logic               valid_o,
    output logic [PC_W-1:0]    pc_plus4_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [5:0]         opcode_o,
    output logic [4:0]         rs_o,
    output logic [4:0]         rt_o,
    output logic [4:0]         rd_o,
    output logic [4:0]         shamt_o,
    output logic [5:0]         funct_o,
    output logic [15:0]        imm16_o,
    output logic [31:0]        stall_cnt_o,
    output logic [31:0]        flush_cnt_o
);

    // Output slot
    logic               out_valid_q, out_valid_d;
    logic [PC_W-1:0]    out_pc_q,    out_pc_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;

    // Skid slot. It only fills while the output slot is valid, so
    // sk_valid_q implies out_valid_q.
    logic               sk_valid_q, sk_valid_d;
    logic [PC_W-1:0]    sk_pc_q,    sk_pc_d;
    logic [INSTR_W-1:0] sk_instr_q, sk_instr_d;

    logic fire;

    // ready depends on registered state only, never on valid_i.
    assign ready_o = ~sk_valid_q;
    assign fire    = valid_i & ready_o;

    always_comb begin
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        sk_valid_d  = sk_valid_q;
        sk_pc_d     = sk_pc_q;
        sk_instr_d  = sk_instr_q;

        if (flush_i) begin
            // Drop everything, including a same-cycle fire; PC+4 holds.
            out_valid_d = 1'b0;
            out_instr_d = NOP_INSTR;
            sk_valid_d  = 1'b0;
        end else if (!stall_i) begin
            if (sk_valid_q) begin
                // Drain the skid first; ready_o = 0 so no fire this cycle.
                out_valid_d = 1'b1;
                out_pc_d    = sk_pc_q;
                out_instr_d = sk_instr_q;
                sk_valid_d  = 1'b0;
            end else if (fire) begin
                out_valid_d = 1'b1;
                out_pc_d    = pc_plus4_i;
                out_instr_d = instr_i;
            end else begin
                out_valid_d = 1'b0;
                out_instr_d = NOP_INSTR;
            end
        end else begin
            if (out_valid_q) begin
                // Decode holds the output; park a new fetch in the skid.
                if (fire) begin
                    sk_valid_d = 1'b1;
                    sk_pc_d    = pc_plus4_i;
                    sk_instr_d = instr_i;
                end
            end else if (fire) begin
                // An empty output slot is a bubble and fills even when stalled.
                out_valid_d = 1'b1;
                out_pc_d    = pc_plus4_i;
                out_instr_d = instr_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= NOP_INSTR;
            sk_valid_q  <= 1'b0;
            sk_pc_q     <= '0;
            sk_instr_q  <= NOP_INSTR;
        end else begin
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            sk_valid_q  <= sk_valid_d;
            sk_pc_q     <= sk_pc_d;
            sk_instr_q  <= sk_instr_d;
        end
    end

    assign valid_o    = out_valid_q;
    assign pc_plus4_o = out_pc_q;
    assign instr_o    = out_instr_q;

    assign opcode_o = out_instr_q[31:26];
    assign rs_o     = out_instr_q[25:21];
    assign rt_o     = out_instr_q[20:16];
    assign rd_o     = out_instr_q[15:11];
    assign shamt_o  = out_instr_q[10:6];
    assign funct_o  = out_instr_q[5:0];
    assign imm16_o  = out_instr_q[15:0];

`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_i && out_valid_q && !flush_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush_i && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = 32'h0;
    assign flush_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_if_id_skid_reg
//
// Self-checking bench for if_id_skid_reg. The reference model treats the
// block as a FIFO of at most two entries, where the head is the output slot:
//   flush empties it; otherwise an unstalled cycle pops the head, and a fire
//   (valid_i with fewer than two entries) pushes.
// Directed sequences pin literal values, and a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_if_id_skid_reg;

`ifdef IFID_PERF_CNT_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, stall_i, flush_i;
    logic [31:0] pc_i, instr_i;
    logic        ready_o, valid_o;
    logic [31:0] pc_o, instr_o;
    logic [5:0]  opcode_o, funct_o;
    logic [4:0]  rs_o, rt_o, rd_o, shamt_o;
    logic [15:0] imm16_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;

    if_id_skid_reg dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .pc_plus4_i  (pc_i),
        .instr_i     (instr_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .valid_o     (valid_o),
        .pc_plus4_o  (pc_o),
        .instr_o     (instr_o),
        .opcode_o    (opcode_o),
        .rs_o        (rs_o),
        .rt_o        (rt_o),
        .rd_o        (rd_o),
        .shamt_o     (shamt_o),
        .funct_o     (funct_o),
        .imm16_o     (imm16_o),
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    logic [31:0] m_stall_cnt, m_flush_cnt;

    task automatic model_reset();
        q.delete();
        m_pc        = 32'h0;
        m_stall_cnt = 32'h0;
        m_flush_cnt = 32'h0;
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            bit   fire;
            ent_t e;
            fire = valid_i && (q.size() < 2);
            if (PerfEn) begin
                if (stall_i && q.size() > 0 && !flush_i && m_stall_cnt != 32'hFFFF_FFFF)
                    m_stall_cnt = m_stall_cnt + 1;
                if (flush_i && m_flush_cnt != 32'hFFFF_FFFF)
                    m_flush_cnt = m_flush_cnt + 1;
            end
            if (flush_i) begin
                q.delete();
            end else begin
                if (!stall_i && q.size() > 0) void'(q.pop_front());
                if (fire) begin
                    e.pc    = pc_i;
                    e.instr = instr_i;
                    q.push_back(e);
                end
            end
            if (q.size() > 0) m_pc = q[0].pc;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [31:0] ei;
        ei = (q.size() > 0) ? q[0].instr : 32'h0;
        check("valid_o",     {31'b0, valid_o}, {31'b0, q.size() > 0});
        check("ready_o",     {31'b0, ready_o}, {31'b0, q.size() < 2});
        check("instr_o",     instr_o, ei);
        check("pc_plus4_o",  pc_o, m_pc);
        check("opcode_o",    {26'b0, opcode_o}, {26'b0, ei[31:26]});
        check("rs_o",        {27'b0, rs_o},     {27'b0, ei[25:21]});
        check("rt_o",        {27'b0, rt_o},     {27'b0, ei[20:16]});
        check("rd_o",        {27'b0, rd_o},     {27'b0, ei[15:11]});
        check("shamt_o",     {27'b0, shamt_o},  {27'b0, ei[10:6]});
        check("funct_o",     {26'b0, funct_o},  {26'b0, ei[5:0]});
        check("imm16_o",     {16'b0, imm16_o},  {16'b0, ei[15:0]});
        check("stall_cnt_o", stall_cnt_o, m_stall_cnt);
        check("flush_cnt_o", flush_cnt_o, m_flush_cnt);
    end

    // Apply inputs at posedge+1, then advance to the next posedge+1.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic st, input logic fl);
        valid_i = v;
        pc_i    = pc;
        instr_i = ins;
        stall_i = st;
        flush_i = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        pc_i = 32'h0; instr_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        check("rst valid_o", {31'b0, valid_o}, 32'd0);
        check("rst instr_o", instr_o, 32'h0);
        check("rst pc_o",    pc_o, 32'h0);
        check("rst ready_o", {31'b0, ready_o}, 32'd1);

        // Load word: opcode 0x23, rs 1, rt 2, imm 4.
        cycle(1'b1, 32'h4, 32'h8C22_0004, 1'b0, 1'b0);
        check("lw valid_o", {31'b0, valid_o}, 32'd1);
        check("lw opcode",  {26'b0, opcode_o}, 32'h23);
        check("lw rs",      {27'b0, rs_o}, 32'd1);
        check("lw rt",      {27'b0, rt_o}, 32'd2);
        check("lw imm16",   {16'b0, imm16_o}, 32'h4);
        check("lw pc",      pc_o, 32'h4);

        // Stall with a held instruction; the next fetch parks in the skid.
        cycle(1'b1, 32'h8, 32'h2001_0005, 1'b0, 1'b0);
        cycle(1'b1, 32'hC, 32'h0022_1820, 1'b1, 1'b0);
        check("skid ready_o", {31'b0, ready_o}, 32'd0);
        check("skid hold",    instr_o, 32'h2001_0005);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("drain instr", instr_o, 32'h0022_1820);
        check("drain funct", {26'b0, funct_o}, 32'h20);
        check("drain ready", {31'b0, ready_o}, 32'd1);
        check("drain pc",    pc_o, 32'hC);

        // Fill both slots, then flush with stall and a valid fetch.
        cycle(1'b1, 32'h10, 32'h1111_1111, 1'b1, 1'b0);
        check("full ready", {31'b0, ready_o}, 32'd0);
        cycle(1'b1, 32'h14, 32'hDEAD_BEEF, 1'b1, 1'b1);
        check("flush valid", {31'b0, valid_o}, 32'd0);
        check("flush instr", instr_o, 32'h0);
        check("flush ready", {31'b0, ready_o}, 32'd1);
        check("flush pc",    pc_o, 32'hC);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("flush gone", {31'b0, valid_o}, 32'd0);

        // Bubble filled while stalled; skid stays empty.
        cycle(1'b1, 32'h18, 32'h2001_FFFF, 1'b1, 1'b0);
        check("bub valid", {31'b0, valid_o}, 32'd1);
        check("bub imm16", {16'b0, imm16_o}, 32'hFFFF);
        check("bub ready", {31'b0, ready_o}, 32'd1);

        // Asynchronous reset between edges with both slots full.
        cycle(1'b1, 32'h1C, 32'h2222_2222, 1'b1, 1'b0);
        check("pre-rst ready", {31'b0, ready_o}, 32'd0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async valid", {31'b0, valid_o}, 32'd0);
        check("async ready", {31'b0, ready_o}, 32'd1);
        check("async instr", instr_o, 32'h0);
        do_reset();

        // Counters: 3 stalled cycles with valid output, then 2 flushes.
        cycle(1'b1, 32'h20, 32'h3333_3333, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check("stall_cnt", stall_cnt_o, PerfEn ? 32'd3 : 32'd0);
        check("flush_cnt", flush_cnt_o, PerfEn ? 32'd2 : 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(3, 0) != 0, $urandom, $urandom,
                  $urandom_range(1, 0) == 1, $urandom_range(15, 0) == 0);
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- IF/ID pipeline register with a one-entry skid buffer, between the instruction-memory/PC stage and the decode stage.
- Captures fetched instruction plus PC+4 and presents them to decode with a valid flag.
- Exposes the slices decode consumes: opcode, rs, rt, rd, shamt, funct, and the 16-bit immediate that feeds the sign-extension unit.
- The skid entry guarantees no fetched instruction is lost when decode stalls in the same cycle fetch delivers.

Parameters:
PC_W, 32, width of the PC+4 field
INSTR_W, 32, instruction width; MIPS field slicing requires 32
NOP_INSTR, 32'h00000000, value driven on instr_o whenever the output slot is empty

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-low reset
valid_i  input  1  fetch presents a valid instruction
ready_o  output  1  block can accept; fire = valid_i & ready_o
pc_plus4_i  input  PC_W  PC+4 of the fetched instruction
instr_i  input  INSTR_W  fetched instruction
stall_i  input  1  decode not consuming this cycle; output slot holds
flush_i  input  1  discard all held and incoming instructions (branch/jump redirect)
valid_o  output  1  output slot holds a real instruction
pc_plus4_o  output  PC_W  registered PC+4
instr_o  output  INSTR_W  registered instruction; NOP_INSTR when valid_o=0
opcode_o  output  6  instr_o[31:26]
rs_o  output  5  instr_o[25:21]
rt_o  output  5  instr_o[20:16]
rd_o  output  5  instr_o[15:11]
shamt_o  output  5  instr_o[10:6]
funct_o  output  6  instr_o[5:0]
imm16_o  output  16  instr_o[15:0], to the sign extender
stall_cnt_o  output  32  stall-cycle counter (optional feature)
flush_cnt_o  output  32  flush counter (optional feature)

Behaviour:
- Reset (rst_i=0, asynchronous): valid_o=0, instr_o=NOP_INSTR, pc_plus4_o=0, skid empty, ready_o=1, counters=0.
- State: OUT slot (valid_o, pc_plus4_o, instr_o) and SK slot (sk_valid, sk_pc, sk_instr).
- ready_o = ~sk_valid. It is a registered-state function and never depends combinationally on valid_i.
- Field outputs are pure combinational slices of instr_o. Latency from fire to valid_o is 1 cycle.
- Priority per rising edge: flush_i > normal update.
- flush_i=1: next cycle valid_o=0, instr_o=NOP_INSTR, sk_valid=0. An instruction firing in the same cycle is dropped. pc_plus4_o holds. stall_i is ignored.
- Normal, stall_i=0 (advance):
  - sk_valid=1: OUT<=SK, sk_valid<=0. No fire is possible this cycle because ready_o=0.
  - sk_valid=0 and fire: OUT<=input.
  - Otherwise: valid_o<=0, instr_o<=NOP_INSTR (bubble).
- Normal, stall_i=1:
  - valid_o=1: OUT holds. A fire loads SK and sets sk_valid=1.
  - valid_o=0: a fire loads OUT directly, so a bubble is filled even while stalled. SK is untouched.
- Ordering is strictly FIFO. At most 2 instructions are in flight.
- Both slots full with stall_i=1: ready_o=0 and everything holds indefinitely.
- Reset asserted mid-operation clears both slots immediately, without waiting for a clock edge.

Optional Feature:
- Macro: IFID_PERF_CNT_EN.
- Defined:
  - stall_cnt_o increments on every cycle with stall_i=1 & valid_o=1 & flush_i=0.
  - flush_cnt_o increments on every cycle with flush_i=1.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: no counter registers are synthesised and both ports are tied to 32'h0.

Test Plan:
- Reset, then fire pc+4=0x4/instr=0x8C220004, stall_i=0 -> next cycle valid_o=1, opcode_o=0x23, rs_o=1, rt_o=2, imm16_o=0x0004.
- valid_o=1 with 0x20010005 held, stall_i=1, fire 0x00221820 -> ready_o=0 next cycle and OUT still 0x20010005. Drop stall -> OUT=0x00221820, funct_o=0x20, ready_o=1.
- Both slots full, flush_i=1 with stall_i=1 and valid_i=1 -> next cycle valid_o=0, instr_o=0, ready_o=1, and the incoming instruction never appears.
- valid_o=0, stall_i=1, fire imm instr 0x2001FFFF -> next cycle valid_o=1, imm16_o=0xFFFF, skid still empty.
- Assert rst_i=0 mid-cycle with both slots full -> valid_o=0 and ready_o=1 before the next clk_i edge.
- With IFID_PERF_CNT_EN: 3 stalled cycles with valid_o=1 plus 2 flushes -> stall_cnt_o=3, flush_cnt_o=2. Without the macro -> both read 0.
